// File: rtl/imem_resp.sv
// Instruction memory responder: one outstanding fetch, fixed response latency,
// word-aligned range-checked decode and a side-band initialization write port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a fetch; outputs quiet
// WAIT   | fetch captured, counting down the remaining latency
// RESP   | response presented, held until rsp_ready_i
module imem_resp #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_err_o,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  logic [31:0]           wr_data_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // WAIT already accounts for one cycle, so the counter covers the rest.
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [31:0]           r_data;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic [32:0]           w_limit;
    logic [31:0]           w_offset;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_err;
    logic                  w_accept;

    // The upper bound is formed in 33 bits so a window touching 2^32 cannot wrap.
    assign w_limit  = {1'b0, BASE} + (33'd1 << (DEPTH_LOG2 + 2));
    assign w_offset = req_addr_i - BASE;
    assign w_idx    = w_offset[DEPTH_LOG2+1:2];
    assign w_err    = (req_addr_i[1:0] != 2'b00) || (req_addr_i < BASE) ||
                      ({1'b0, req_addr_i} >= w_limit);
    assign w_accept = (r_state == S_IDLE) && req_valid_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid_i) w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP: if (rsp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture response at acceptance and run the latency counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= 4'd0;
            r_data <= 32'h0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= CNT_LOAD;
            r_data <= w_err ? 32'h0 : r_mem[w_idx];
            r_err  <= w_err;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Initialization write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en_i) r_mem[wr_idx_i] <= wr_data_i;
    end

    // Outputs decoded from state; response fields forced quiet outside RESP
    always_comb begin
        req_ready_o = (r_state == S_IDLE);
        rsp_valid_o = (r_state == S_RESP);
        rsp_data_o  = (r_state == S_RESP) ? r_data : 32'h0;
        rsp_err_o   = (r_state == S_RESP) ? r_err : 1'b0;
    end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter BASE, 32'h8000_0000, byte address of word 0.
REQ-002 Parameter DEPTH_LOG2, 12, memory holds 2^DEPTH_LOG2 32-bit words.
REQ-003 Parameter LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-004 clk_i  input  1  clock, all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  1  fetch request present.
REQ-007 req_ready_o  output  1  responder can accept a request.
REQ-008 req_addr_i  input  32  fetch byte address (core PC).
REQ-009 rsp_valid_o  output  1  response word valid.
REQ-010 rsp_ready_i  input  1  requester consumes response.
REQ-011 rsp_data_o  output  32  fetched instruction word.
REQ-012 rsp_err_o  output  1  request was misaligned or out of range.
REQ-013 wr_en_i  input  1  initialization write strobe.
REQ-014 wr_idx_i  input  DEPTH_LOG2  word index for write.
REQ-015 wr_data_i  input  32  write data.

Function
REQ-016 FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-017 req_ready_o SHALL be 1 exactly when state is IDLE (combinational from state).
REQ-018 Acceptance: rising edge with state IDLE and req_valid_i=1; otherwise the request is ignored and not stored.
REQ-019 Decode at acceptance: err = (addr[1:0]!=0) or (addr < BASE) or (addr >= BASE + 4*2^DEPTH_LOG2), unsigned 32-bit compare; idx = (addr - BASE)[DEPTH_LOG2+1:2].
REQ-020 At acceptance, data register captures mem[idx] as it was before any write in the same edge (read-before-write), or 32'h0 if err; err register captures err.
REQ-021 LATENCY=1: acceptance transitions IDLE->RESP directly; LATENCY>1: IDLE->WAIT with counter loaded LATENCY-2, decrementing each cycle; WAIT->RESP when counter is 0.
REQ-022 rsp_valid_o SHALL be 1 exactly in RESP; rsp_data_o/rsp_err_o SHALL hold the captured values stable for the whole of RESP.
REQ-023 RESP->IDLE on an edge with rsp_ready_i=1; rsp_ready_i outside RESP has no effect.
REQ-024 No same-cycle turnaround: after response handshake, req_ready_o rises the following cycle; back-to-back throughput is one request per LATENCY+1 cycles minimum.
REQ-025 rsp_data_o and rsp_err_o SHALL be 0 when not in RESP.
REQ-026 Writes: wr_en_i=1 writes wr_data_i to mem[wr_idx_i] at the edge, in any state; a write during WAIT/RESP SHALL NOT alter the captured response.
REQ-027 req_addr_i changes after acceptance SHALL NOT affect the pending response.

Reset
REQ-028 rst_i=1 forces state IDLE, counter 0, captured data 0, captured err 0 immediately; outputs req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0.
REQ-029 Reset during WAIT or RESP discards the pending response; no rsp_valid_o pulse follows reset release.
REQ-030 Memory contents are not reset.

Verification
REQ-031 Write mem[0]=32'h0010_0093, mem[1]=32'h0020_0113; LATENCY=2, request 32'h8000_0000 accepted at edge T -> rsp_valid_o=1 from T+2, rsp_data_o=32'h0010_0093, rsp_err_o=0; rsp_ready_i=1 at T+2 -> req_ready_o=1 at T+3.
REQ-032 Backpressure: rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and rsp_data_o held constant 5 cycles, req_ready_o=0 throughout; write to mem[0] meanwhile does not change rsp_data_o.
REQ-033 Errors: request 32'h8000_0002 -> rsp_err_o=1, rsp_data_o=0; request 32'h7FFF_FFFC and 32'h8000_4000 (DEPTH_LOG2=12) -> rsp_err_o=1.
REQ-034 Same-edge collision: wr_en_i to idx 1 with 32'hDEAD_BEEF at the acceptance edge of 32'h8000_0004 -> rsp_data_o=32'h0020_0113; next request to same address -> 32'hDEAD_BEEF.
REQ-035 Reset in WAIT: assert rst_i one cycle after acceptance -> rsp_valid_o stays 0, req_ready_o=1 immediately and after release.
REQ-036 LATENCY=1 and LATENCY=15 builds: rsp_valid_o rises exactly 1 and 15 cycles after acceptance respectively.
